// File: rtl/pl_bram_addr_gen.sv
// BRAM port-B address generator: walks a [base, last] window in read or write mode, one-shot or circular.
// Latency: one beat appears on pl_en/pl_addr the cycle after each ar_valid cycle; all outputs registered.
// Backpressure: ar_valid gates every beat; when it is low the pointer holds and pl_en drops; abort cancels at once.
module pl_bram_addr_gen #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              ar_valid,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic              wr_mode,
  input  logic              wrap_en,
  output logic [ADDR_W-1:0] pl_addr,
  output logic              pl_en,
  output logic              pl_wr_en,
  output logic              busy,
  output logic              last,
  output logic              done,
  output logic              cfg_err,
  output logic [CNT_W-1:0]  wrap_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] last_q;
  logic              wr_q;
  logic              wrap_q;
  logic [CNT_W-1:0]  wrap_cnt_nxt;

  logic cfg_ok;
  logic accept;
  logic reject;
  logic fire;
  logic at_last;
  logic end_beat;
  logic wrap_beat;

  // An inverted window can never be walked, so it is refused up front.
  assign cfg_ok    = (last_addr >= base_addr);
  // abort outranks start in IDLE and suppresses the beat of its own cycle in RUN.
  assign accept    = (state == S_IDLE) && start && !abort && cfg_ok;
  assign reject    = (state == S_IDLE) && start && !abort && !cfg_ok;
  assign fire      = (state == S_RUN) && ar_valid && !abort;
  assign at_last   = (ptr == last_q);
  assign end_beat  = fire && at_last && !wrap_q;
  assign wrap_beat = fire && at_last && wrap_q;

  // Next-state selection; abort returns to IDLE from anywhere.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (accept) state_nxt = S_RUN;
        S_RUN:   if (end_beat) state_nxt = S_FIN;
        S_FIN:   state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Pointer: reload on accept, rewind to base on a wrapping last beat, otherwise step per beat.
  // Rewinding at last (instead of incrementing) keeps a full-range window from overflowing.
  always_comb begin
    ptr_nxt = ptr;
    if (accept) begin
      ptr_nxt = base_addr;
    end else if (wrap_beat) begin
      ptr_nxt = base_q;
    end else if (fire && !at_last) begin
      ptr_nxt = ptr + ADDR_W'(1);
    end
  end

  // Wrap counter clears per transfer and sticks at all-ones instead of rolling over.
  always_comb begin
    wrap_cnt_nxt = wrap_cnt;
    if (accept) begin
      wrap_cnt_nxt = '0;
    end else if (wrap_beat && (wrap_cnt != {CNT_W{1'b1}})) begin
      wrap_cnt_nxt = wrap_cnt + CNT_W'(1);
    end
  end

  // State and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Window and mode are captured only on an accepted start, so a start during RUN cannot disturb them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q <= '0;
      last_q <= '0;
      wr_q   <= 1'b0;
      wrap_q <= 1'b0;
    end else if (accept) begin
      base_q <= base_addr;
      last_q <= last_addr;
      wr_q   <= wr_mode;
      wrap_q <= wrap_en;
    end
  end

  // Wrap counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_cnt <= '0;
    end else begin
      wrap_cnt <= wrap_cnt_nxt;
    end
  end

  // Beat outputs: one registered beat per fire; pl_addr holds between beats, pl_wr_en only with pl_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pl_addr  <= '0;
      pl_en    <= 1'b0;
      pl_wr_en <= 1'b0;
      last     <= 1'b0;
    end else begin
      pl_en    <= fire;
      pl_wr_en <= fire && wr_q;
      last     <= fire && at_last;
      if (fire) begin
        pl_addr <= ptr;
      end
    end
  end

  // Status outputs: busy mirrors RUN, done lands with the final one-shot beat, cfg_err flags a refused start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      busy    <= (state_nxt == S_RUN);
      done    <= end_beat;
      cfg_err <= reject;
    end
  end

endmodule

// File: tb/tb_pl_bram_addr_gen.sv
// Bench for pl_bram_addr_gen: a 16-bit and a 4-bit instance share stimulus and are scored by a beat-index model.
// Latency: expectations for each edge are formed from the inputs applied before that edge.
// Backpressure: ar_valid is toggled directly and randomly; all stimulus runs for a fixed number of cycles.
module tb_pl_bram_addr_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, ar_valid, wr_mode, wrap_en;
  logic [15:0] base_addr, last_addr;

  logic [15:0] a16;
  logic [3:0]  a4;
  logic        en16, wr16, busy16, last16, done16, err16;
  logic        en4, wr4, busy4, last4, done4, err4;
  logic [7:0]  wc16, wc4;

  int n_tests = 0;
  int n_fail  = 0;
  int beats16 = 0;
  int beats4  = 0;

  always #5 clk = ~clk;

  pl_bram_addr_gen #(.ADDR_W(16), .CNT_W(8)) dut16 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .ar_valid(ar_valid),
    .base_addr(base_addr), .last_addr(last_addr), .wr_mode(wr_mode), .wrap_en(wrap_en),
    .pl_addr(a16), .pl_en(en16), .pl_wr_en(wr16), .busy(busy16), .last(last16),
    .done(done16), .cfg_err(err16), .wrap_cnt(wc16)
  );

  pl_bram_addr_gen #(.ADDR_W(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .ar_valid(ar_valid),
    .base_addr(base_addr[3:0]), .last_addr(last_addr[3:0]), .wr_mode(wr_mode), .wrap_en(wrap_en),
    .pl_addr(a4), .pl_en(en4), .pl_wr_en(wr4), .busy(busy4), .last(last4),
    .done(done4), .cfg_err(err4), .wrap_cnt(wc4)
  );

  // Reference model, one slot per instance. Mode: 0 idle, 1 running, 2 finishing.
  int m_mode[2];
  int m_base[2];
  int m_last[2];
  int m_n[2];
  int m_k[2];
  int m_wr[2];
  int m_wrap[2];
  int e_addr[2];
  int e_en[2];
  int e_wr[2];
  int e_last[2];
  int e_done[2];
  int e_err[2];
  int e_busy[2];
  int e_wcnt[2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int id = 0; id < 2; id++) begin
      m_mode[id] = 0; m_base[id] = 0; m_last[id] = 0; m_n[id] = 1; m_k[id] = 0;
      m_wr[id] = 0; m_wrap[id] = 0;
      e_addr[id] = 0; e_en[id] = 0; e_wr[id] = 0; e_last[id] = 0;
      e_done[id] = 0; e_err[id] = 0; e_busy[id] = 0; e_wcnt[id] = 0;
    end
  endtask

  // Beat k of a transfer addresses base + (k mod window size); the window ends on k mod size == size-1.
  task automatic model_edge(input int id);
    int mask, b, l, pos;
    mask = (id == 0) ? 32'hFFFF : 32'hF;
    b = int'(base_addr) & mask;
    l = int'(last_addr) & mask;
    e_en[id] = 0; e_wr[id] = 0; e_last[id] = 0; e_done[id] = 0; e_err[id] = 0;
    if (abort) begin
      m_mode[id] = 0;
    end else if (m_mode[id] == 0) begin
      if (start) begin
        if (l >= b) begin
          m_base[id] = b; m_last[id] = l; m_n[id] = l - b + 1; m_k[id] = 0;
          m_wr[id] = int'(wr_mode); m_wrap[id] = int'(wrap_en);
          e_wcnt[id] = 0; m_mode[id] = 1;
        end else begin
          e_err[id] = 1;
        end
      end
    end else if (m_mode[id] == 1) begin
      if (ar_valid) begin
        pos = m_k[id] % m_n[id];
        e_en[id] = 1;
        e_addr[id] = (m_base[id] + pos) & mask;
        e_wr[id] = m_wr[id];
        e_last[id] = (pos == m_n[id] - 1) ? 1 : 0;
        m_k[id]++;
        if (pos == m_n[id] - 1) begin
          if (m_wrap[id] != 0) begin
            if (e_wcnt[id] < 255) e_wcnt[id]++;
          end else begin
            e_done[id] = 1;
            m_mode[id] = 2;
          end
        end
      end
    end else begin
      m_mode[id] = 0;
    end
    e_busy[id] = (m_mode[id] == 1) ? 1 : 0;
  endtask

  task automatic check_dut(input int id);
    logic [31:0] addr, en, wr, bsy, lst, dn, err, wc;
    if (id == 0) begin
      addr = 32'(a16); en = 32'(en16); wr = 32'(wr16); bsy = 32'(busy16);
      lst = 32'(last16); dn = 32'(done16); err = 32'(err16); wc = 32'(wc16);
      if (en16) beats16++;
    end else begin
      addr = 32'(a4); en = 32'(en4); wr = 32'(wr4); bsy = 32'(busy4);
      lst = 32'(last4); dn = 32'(done4); err = 32'(err4); wc = 32'(wc4);
      if (en4) beats4++;
    end
    check_eq($sformatf("d%0d pl_addr", id), addr, 32'(e_addr[id]));
    check_eq($sformatf("d%0d pl_en", id), en, 32'(e_en[id]));
    check_eq($sformatf("d%0d pl_wr_en", id), wr, 32'(e_wr[id]));
    check_eq($sformatf("d%0d busy", id), bsy, 32'(e_busy[id]));
    check_eq($sformatf("d%0d last", id), lst, 32'(e_last[id]));
    check_eq($sformatf("d%0d done", id), dn, 32'(e_done[id]));
    check_eq($sformatf("d%0d cfg_err", id), err, 32'(e_err[id]));
    check_eq($sformatf("d%0d wrap_cnt", id), wc, 32'(e_wcnt[id]));
  endtask

  // Called at posedge+1: apply inputs, cross the next edge, update the model, check both instances.
  task automatic step(input logic s, input logic ab, input logic av, input logic [15:0] b,
                      input logic [15:0] l, input logic wr, input logic wp);
    start = s; abort = ab; ar_valid = av; base_addr = b; last_addr = l; wr_mode = wr; wrap_en = wp;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check_dut(0);
    check_dut(1);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  logic [15:0] rb, rl;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; ar_valid = 1'b0;
    base_addr = '0; last_addr = '0; wr_mode = 1'b0; wrap_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_dut(0);
    check_dut(1);
    rst = 1'b0;

    // Basic read: 0x10..0x13 one-shot.
    beats16 = 0;
    step(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0013, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
    idle_steps(2);
    check_eq("basic beat count", 32'(beats16), 32'd4);

    // Gapped write: 0x100..0x102 with ar_valid 1,0,1,1.
    beats16 = 0;
    step(1'b1, 1'b0, 1'b0, 16'h0100, 16'h0102, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
    idle_steps(2);
    check_eq("gapped beat count", 32'(beats16), 32'd3);

    // Wrap over E..F for six beats.
    step(1'b1, 1'b0, 1'b0, 16'h000E, 16'h000F, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
    check_eq("wrap count E..F", 32'(wc4), 32'd3);
    step(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    idle_steps(1);

    // Full 4-bit range, 17 beats, plus a start during RUN that must be ignored.
    step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h000F, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++)
      step(i == 5, 1'b0, 1'b1, 16'h0003, 16'h0004, 1'b1, 1'b0);
    check_eq("full-range wrap count", 32'(wc4), 32'd1);
    step(1'b0, 1'b1, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
    idle_steps(1);

    // Abort on the third beat of a 10-beat one-shot.
    beats16 = 0;
    step(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0029, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
    check_eq("abort beat count", 32'(beats16), 32'd2);

    // Inverted window, then start together with abort, then a single-address one-shot.
    step(1'b1, 1'b0, 1'b1, 16'h0005, 16'h0003, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 16'h0001, 16'h0002, 1'b0, 1'b0);
    idle_steps(1);
    beats16 = 0;
    step(1'b1, 1'b0, 1'b0, 16'h0007, 16'h0007, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
    check_eq("single-address beat count", 32'(beats16), 32'd1);

    // Asynchronous reset in the middle of a run.
    step(1'b1, 1'b0, 1'b0, 16'h0040, 16'h004F, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_dut(0);
    check_dut(1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    beats16 = 0;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
    check_eq("no beats after reset", 32'(beats16), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rb = 16'($urandom);
      if ($urandom_range(0, 9) == 0) rl = rb - 16'd1;
      else rl = rb + 16'($urandom_range(0, 6));
      step($urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
           rb, rl, 1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
